signed_or_unsigned_div: RTL and testbench
=========================================

Name: signed_or_unsigned_div

Overview:
Multi-cycle restoring divider; the inverse operation of the team's signed_or_unsigned_mul.
- Computes quotient and remainder of two n-bit operands, one quotient bit per clock.
- Operands are treated as unsigned or two's-complement signed, selected per operation.
- Operands enter through a valid/ready handshake; results leave through a second valid/ready handshake, so the block drops into the arithmetic pipeline next to the multiplier.

Parameters:
n, 4, operand/result width in bits (n >= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
arg_vld  input  1  operands a, b, signed_div presented
arg_rdy  output  1  block can accept operands (high only in IDLE)
a  input  n  dividend
b  input  n  divisor
signed_div  input  1  1 = two's-complement signed, 0 = unsigned
res_vld  output  1  quo, rem, div_by_zero valid
res_rdy  input  1  downstream accepts result
quo  output  n  quotient
rem  output  n  remainder
div_by_zero  output  1  b was zero for this result

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (asynchronous, any state): state = IDLE, iteration counter = 0, res_vld = 0, quo = 0, rem = 0, div_by_zero = 0.
- arg_rdy is decoded from state, so it reads 1 whenever the block is in IDLE, including right after reset.
- States:
  - IDLE: arg_rdy = 1. On arg_vld & arg_rdy at edge k, latch the operand magnitudes, the sign flags (sign of a; sign of a XOR sign of b, used only when signed_div = 1), signed_div and (b == 0). Go to BUSY, counter = 0.
  - BUSY: one restoring step per edge, using an (n+1)-bit partial remainder. Edges k+1 .. k+n perform the n steps. At edge k+n, go to DONE with the sign-corrected quo and rem registered and res_vld = 1.
  - DONE: res_vld = 1 and outputs held stable. On res_vld & res_rdy, go to IDLE at that edge; res_vld falls.
- No overlap: arg_rdy = 0 in BUSY and DONE. Minimum initiation interval is n+2 cycles.
- Latency: res_vld first seen high n cycles after the accepting edge.
- Operand sampling: a, b and signed_div are sampled only at the accept edge. Changes during BUSY or DONE are ignored.
- Signed rules (match SystemVerilog / and %):
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Identity a = quo*b + rem holds in n bits.
  - Magnitude of smin (2^(n-1)) is held in n bits unsigned.
- Overflow, signed smin / -1: quo = smin, rem = 0, div_by_zero = 0.
- Divide by zero (b == 0), either mode: quo = all ones, rem = a, div_by_zero = 1. Latency is the same as a normal operation.
- After the DONE handshake, quo, rem and div_by_zero keep their last values until the next result is written; they are meaningful only while res_vld = 1.
- Reset mid-operation (BUSY or DONE): the operation is abandoned with no result, and the block returns to IDLE.

Decomposition:
- Package div_pkg holds:
  - the state enum typedef (IDLE, BUSY, DONE);
  - helper functions for magnitude (abs) and conditional negate, parameterised by width.
- One natural sub-module, div_step: combinational single restoring iteration.
  - Inputs: partial remainder (n+1 bits), next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
- Top level keeps the FSM, counter, operand/quotient shift registers and sign fix-up.

Test Plan (n = 4):
- Unsigned 13 / 3 -> quo 4, rem 1, div_by_zero 0. res_vld rises exactly 4 edges after the accept edge. arg_rdy = 0 throughout BUSY/DONE.
- Signed -7 / 2 (1001 / 0010) -> quo -3 (1101), rem -1 (1111). Signed 7 / -2 -> quo -3 (1101), rem 1 (0001).
- Signed -8 / -1 -> quo 1000, rem 0000. Unsigned 9 / 0 -> quo 1111, rem 1001, div_by_zero 1. Signed -3 / 0 -> quo 1111, rem 1101, div_by_zero 1.
- Backpressure: hold res_rdy = 0 for 5 cycles in DONE -> res_vld, quo and rem stay stable. Toggle arg_vld and a during this window -> nothing accepted. Raise res_rdy -> IDLE next edge, arg_rdy = 1.
- Drop rst_n after the 2nd BUSY step of 14 / 5 -> res_vld, quo, rem and div_by_zero go to 0 immediately, with no clock needed. After release, a new 6 / 4 gives quo 1, rem 2.
- Exhaustive sweep, random res_rdy stalls: all 256 unsigned and all 256 signed pairs, b != 0, compared against SV / and %. Add the b == 0 and smin / -1 rules above. Scoreboard checks each accepted operation yields exactly one result, in order.

Source files
------------

// File: rtl/signed_or_unsigned_div_pkg.sv
// Shared types and arithmetic helpers for the signed/unsigned restoring divider.
package div_pkg;

   // Widest operand the helpers handle; callers zero-extend in and truncate out.
   localparam int unsigned DIV_MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   // Two's-complement negate when neg is set; correct for any width after truncation.
   function automatic logic [DIV_MAX_W-1:0] cond_neg(input logic [DIV_MAX_W-1:0] x,
                                                     input logic                 neg);
      return neg ? (~x + DIV_MAX_W'(1)) : x;
   endfunction

   // Magnitude of a w-bit two's-complement value held zero-extended in x.
   // The magnitude of the most negative value fits in w bits unsigned.
   function automatic logic [DIV_MAX_W-1:0] abs_mag(input logic [DIV_MAX_W-1:0] x,
                                                    input int unsigned          w);
      logic sign;
      sign = |(x & (DIV_MAX_W'(1) << (w - 1)));
      return cond_neg(x, sign);
   endfunction

endpackage

// File: rtl/signed_or_unsigned_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
   parameter int unsigned n = 4
) (
   input  logic [n:0]   pr_in,
   input  logic         dvd_bit,
   input  logic [n-1:0] dvs,
   output logic [n:0]   pr_out,
   output logic         q_bit
);

   logic [n+1:0] trial;

   // Borrow out of the (n+2)-bit subtraction means the divisor did not fit.
   always_comb begin
      trial  = {pr_in, dvd_bit} - {2'b00, dvs};
      q_bit  = ~trial[n+1];
      pr_out = q_bit ? trial[n:0] : {pr_in[n-1:0], dvd_bit};
   end

endmodule

// File: rtl/signed_or_unsigned_div.sv
// Multi-cycle restoring divider, one quotient bit per clock, unsigned or signed operands.
module signed_or_unsigned_div
   import div_pkg::*;
#(
   parameter int unsigned n = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         arg_vld,
   output logic         arg_rdy,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         signed_div,
   output logic         res_vld,
   input  logic         res_rdy,
   output logic [n-1:0] quo,
   output logic [n-1:0] rem,
   output logic         div_by_zero
);

   localparam int unsigned CW = (n > 2) ? $clog2(n) : 1;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [n:0]     pr_q, pr_d;
   logic [n-1:0]   sh_q, sh_d;
   logic [n-1:0]   dvs_q, dvs_d;
   logic [n-1:0]   a_q, a_d;
   logic           qneg_q, qneg_d;
   logic           rneg_q, rneg_d;
   logic           dbz_q, dbz_d;
   logic           res_vld_q, res_vld_d;
   logic [n-1:0]   quo_q, quo_d;
   logic [n-1:0]   rem_q, rem_d;
   logic           div_by_zero_q, div_by_zero_d;

   logic [n-1:0]   a_mag, b_mag;
   logic [n:0]     step_pr;
   logic           step_q;
   logic [n-1:0]   quo_mag, quo_fix, rem_fix;

   div_step #(.n(n)) u_step (
      .pr_in   (pr_q),
      .dvd_bit (sh_q[n-1]),
      .dvs     (dvs_q),
      .pr_out  (step_pr),
      .q_bit   (step_q)
   );

   assign arg_rdy     = (state_q == IDLE);
   assign res_vld     = res_vld_q;
   assign quo         = quo_q;
   assign rem         = rem_q;
   assign div_by_zero = div_by_zero_q;

   // Operand magnitudes and sign-corrected final results of the last step.
   always_comb begin
      a_mag   = signed_div ? n'(abs_mag(DIV_MAX_W'(a), n)) : a;
      b_mag   = signed_div ? n'(abs_mag(DIV_MAX_W'(b), n)) : b;
      quo_mag = {sh_q[n-2:0], step_q};
      quo_fix = n'(cond_neg(DIV_MAX_W'(quo_mag), qneg_q));
      rem_fix = n'(cond_neg(DIV_MAX_W'(step_pr[n-1:0]), rneg_q));
   end

   // Next-state logic: accept in IDLE, iterate in BUSY, hold result in DONE.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pr_d          = pr_q;
      sh_d          = sh_q;
      dvs_d         = dvs_q;
      a_d           = a_q;
      qneg_d        = qneg_q;
      rneg_d        = rneg_q;
      dbz_d         = dbz_q;
      res_vld_d     = res_vld_q;
      quo_d         = quo_q;
      rem_d         = rem_q;
      div_by_zero_d = div_by_zero_q;
      case (state_q)
         IDLE: begin
            if (arg_vld) begin
               state_d = BUSY;
               cnt_d   = '0;
               pr_d    = '0;
               sh_d    = a_mag;
               dvs_d   = b_mag;
               a_d     = a;
               qneg_d  = signed_div & (a[n-1] ^ b[n-1]);
               rneg_d  = signed_div & a[n-1];
               dbz_d   = (b == '0);
            end
         end
         BUSY: begin
            // The shift register holds remaining dividend bits above the quotient bits.
            pr_d  = step_pr;
            sh_d  = quo_mag;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(n - 1)) begin
               state_d       = DONE;
               res_vld_d     = 1'b1;
               quo_d         = dbz_q ? '1 : quo_fix;
               rem_d         = dbz_q ? a_q : rem_fix;
               div_by_zero_d = dbz_q;
            end
         end
         DONE: begin
            if (res_rdy) begin
               state_d   = IDLE;
               res_vld_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         pr_q          <= '0;
         sh_q          <= '0;
         dvs_q         <= '0;
         a_q           <= '0;
         qneg_q        <= 1'b0;
         rneg_q        <= 1'b0;
         dbz_q         <= 1'b0;
         res_vld_q     <= 1'b0;
         quo_q         <= '0;
         rem_q         <= '0;
         div_by_zero_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pr_q          <= pr_d;
         sh_q          <= sh_d;
         dvs_q         <= dvs_d;
         a_q           <= a_d;
         qneg_q        <= qneg_d;
         rneg_q        <= rneg_d;
         dbz_q         <= dbz_d;
         res_vld_q     <= res_vld_d;
         quo_q         <= quo_d;
         rem_q         <= rem_d;
         div_by_zero_q <= div_by_zero_d;
      end
   end

endmodule

// File: tb/tb_signed_or_unsigned_div.sv
// Scoreboard bench for signed_or_unsigned_div at n = 4.
module tb_signed_or_unsigned_div;

   localparam int unsigned N = 4;

   typedef struct packed {
      logic [3:0] quo;
      logic [3:0] rem;
      logic       dbz;
   } res_t;

   logic       clk;
   logic       rst_n;
   logic       arg_vld;
   logic       arg_rdy;
   logic [3:0] a;
   logic [3:0] b;
   logic       signed_div;
   logic       res_vld;
   logic       res_rdy;
   logic [3:0] quo;
   logic [3:0] rem;
   logic       div_by_zero;

   int unsigned tests_run;
   int unsigned tests_failed;
   res_t        exp_q[$];

   signed_or_unsigned_div #(.n(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .arg_vld     (arg_vld),
      .arg_rdy     (arg_rdy),
      .a           (a),
      .b           (b),
      .signed_div  (signed_div),
      .res_vld     (res_vld),
      .res_rdy     (res_rdy),
      .quo         (quo),
      .rem         (rem),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, run=%0d failed=%0d", tests_run, tests_failed);
      $fatal(1);
   end

   // Reference: SystemVerilog / and % plus the divide-by-zero and overflow rules.
   function automatic res_t ref_div(input logic [3:0] x, input logic [3:0] y, input logic s);
      res_t              res;
      logic signed [3:0] sx, sy;
      sx = x;
      sy = y;
      if (y == 4'd0) begin
         res = '{quo: 4'hF, rem: x, dbz: 1'b1};
      end else if (s && x == 4'h8 && y == 4'hF) begin
         res = '{quo: 4'h8, rem: 4'h0, dbz: 1'b0};
      end else if (s) begin
         res.quo = 4'(sx / sy);
         res.rem = 4'(sx % sy);
         res.dbz = 1'b0;
      end else begin
         res.quo = x / y;
         res.rem = x % y;
         res.dbz = 1'b0;
      end
      return res;
   endfunction

   // Drive one operation, wait for its result, stall, then take it.
   task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic ts,
                         input res_t expv, input int unsigned stall,
                         output res_t got, output int unsigned lat,
                         output logic iface_ok, output logic post_ok, output logic ok);
      int unsigned w;
      ok       = 1'b1;
      iface_ok = 1'b1;
      post_ok  = 1'b0;
      lat      = 0;
      got      = '0;
      w        = 0;
      while (arg_rdy !== 1'b1 && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      if (arg_rdy !== 1'b1) begin
         ok = 1'b0;
         return;
      end
      exp_q.push_back(expv);
      a = ta; b = tb_v; signed_div = ts; arg_vld = 1'b1;
      @(posedge clk); #1;
      arg_vld = 1'b0;
      a = 4'($urandom); b = 4'($urandom); signed_div = 1'($urandom);
      while (res_vld !== 1'b1 && lat < N + 4) begin
         if (arg_rdy !== 1'b0) iface_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (res_vld !== 1'b1) begin
         ok = 1'b0;
         return;
      end
      got = '{quo: quo, rem: rem, dbz: div_by_zero};
      repeat (stall) begin
         if (arg_rdy !== 1'b0) iface_ok = 1'b0;
         @(posedge clk); #1;
         if (res_vld !== 1'b1 || {quo, rem, div_by_zero} !== got) iface_ok = 1'b0;
      end
      res_rdy = 1'b1;
      @(posedge clk); #1;
      res_rdy = 1'b0;
      post_ok = (res_vld === 1'b0) && (arg_rdy === 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      tests_run++;
      if ({res_vld, quo, rem, div_by_zero, arg_rdy} !== {1'b0, 4'h0, 4'h0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL reset_state: got vld=%b quo=%h rem=%h dbz=%b rdy=%b, want 0 0 0 0 1",
                  res_vld, quo, rem, div_by_zero, arg_rdy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_unsigned_basic();
      res_t e, got; int unsigned lat; logic iok, pok, ok;
      run_op(4'd13, 4'd3, 1'b0, '{quo: 4'd4, rem: 4'd1, dbz: 1'b0}, 0, got, lat, iok, pok, ok);
      tests_run++;
      if (!ok || exp_q.size() == 0) begin
         tests_failed++;
         $display("FAIL basic_timeout: no result for 13/3 within bound");
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            tests_failed++;
            $display("FAIL basic_13_3: got %h/%h/%b, want %h/%h/%b", got.quo, got.rem, got.dbz, e.quo, e.rem, e.dbz);
         end
         tests_run++;
         if (lat !== N) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d edges, want %0d", lat, N);
         end
         tests_run++;
         if (iok !== 1'b1 || pok !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_handshake: arg_rdy/hold ok=%b, post ok=%b, want 1 1", iok, pok);
         end
      end
   endtask

   task automatic test_signed();
      logic [3:0] ta[2] = '{4'b1001, 4'b0111};
      logic [3:0] tbv[2] = '{4'b0010, 4'b1110};
      res_t       te[2] = '{'{quo: 4'b1101, rem: 4'b1111, dbz: 1'b0},
                            '{quo: 4'b1101, rem: 4'b0001, dbz: 1'b0}};
      res_t e, got; int unsigned lat; logic iok, pok, ok;
      for (int i = 0; i < 2; i++) begin
         run_op(ta[i], tbv[i], 1'b1, te[i], 1, got, lat, iok, pok, ok);
         tests_run++;
         if (!ok || exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL signed_timeout: a=%h b=%h", ta[i], tbv[i]);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               tests_failed++;
               $display("FAIL signed_%h_%h: got %h/%h/%b, want %h/%h/%b", ta[i], tbv[i],
                        got.quo, got.rem, got.dbz, e.quo, e.rem, e.dbz);
            end
         end
      end
   endtask

   task automatic test_special();
      logic [3:0] ta[3] = '{4'b1000, 4'd9, 4'b1101};
      logic [3:0] tbv[3] = '{4'b1111, 4'd0, 4'd0};
      logic       ts[3] = '{1'b1, 1'b0, 1'b1};
      res_t       te[3] = '{'{quo: 4'b1000, rem: 4'b0000, dbz: 1'b0},
                            '{quo: 4'b1111, rem: 4'b1001, dbz: 1'b1},
                            '{quo: 4'b1111, rem: 4'b1101, dbz: 1'b1}};
      res_t e, got; int unsigned lat; logic iok, pok, ok;
      for (int i = 0; i < 3; i++) begin
         run_op(ta[i], tbv[i], ts[i], te[i], 0, got, lat, iok, pok, ok);
         tests_run++;
         if (!ok || exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL special_timeout: a=%h b=%h s=%b", ta[i], tbv[i], ts[i]);
         end else begin
            e = exp_q.pop_front();
            if (got !== e || lat !== N) begin
               tests_failed++;
               $display("FAIL special_%h_%h_s%b: got %h/%h/%b lat %0d, want %h/%h/%b lat %0d", ta[i], tbv[i], ts[i],
                        got.quo, got.rem, got.dbz, lat, e.quo, e.rem, e.dbz, N);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      res_t e, got; int unsigned w; logic hold_ok;
      exp_q.push_back('{quo: 4'd5, rem: 4'd1, dbz: 1'b0});
      a = 4'd11; b = 4'd2; signed_div = 1'b0; arg_vld = 1'b1;
      @(posedge clk); #1;
      arg_vld = 1'b0;
      w = 0;
      while (res_vld !== 1'b1 && w < N + 4) begin
         @(posedge clk); #1;
         w++;
      end
      tests_run++;
      if (res_vld !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_timeout: res_vld=%b after %0d edges, want 1", res_vld, w);
         return;
      end
      got = '{quo: quo, rem: rem, dbz: div_by_zero};
      hold_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         arg_vld = ~arg_vld;
         a = a + 4'd3;
         @(posedge clk); #1;
         if (res_vld !== 1'b1 || arg_rdy !== 1'b0 || {quo, rem, div_by_zero} !== got) hold_ok = 1'b0;
      end
      arg_vld = 1'b0;
      if (hold_ok !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_hold: outputs changed or arg_rdy rose during stall, ok=%b want 1", hold_ok);
      end
      tests_run++;
      e = exp_q.pop_front();
      if (got !== e) begin
         tests_failed++;
         $display("FAIL bp_11_2: got %h/%h/%b, want %h/%h/%b", got.quo, got.rem, got.dbz, e.quo, e.rem, e.dbz);
      end
      res_rdy = 1'b1;
      @(posedge clk); #1;
      res_rdy = 1'b0;
      tests_run++;
      if (res_vld !== 1'b0 || arg_rdy !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_release: got vld=%b rdy=%b, want 0 1", res_vld, arg_rdy);
      end
   endtask

   task automatic test_reset_mid();
      res_t e, got; int unsigned lat; logic iok, pok, ok;
      exp_q.push_back('{quo: 4'd2, rem: 4'd4, dbz: 1'b0});
      a = 4'd14; b = 4'd5; signed_div = 1'b0; arg_vld = 1'b1;
      @(posedge clk); #1;
      arg_vld = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      void'(exp_q.pop_front());
      #1;
      tests_run++;
      if ({res_vld, quo, rem, div_by_zero, arg_rdy} !== {1'b0, 4'h0, 4'h0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL mid_reset: got vld=%b quo=%h rem=%h dbz=%b rdy=%b, want 0 0 0 0 1",
                  res_vld, quo, rem, div_by_zero, arg_rdy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(4'd6, 4'd4, 1'b0, '{quo: 4'd1, rem: 4'd2, dbz: 1'b0}, 0, got, lat, iok, pok, ok);
      tests_run++;
      if (!ok || exp_q.size() != 1) begin
         tests_failed++;
         $display("FAIL after_reset_timeout: ok=%b queue=%0d, want 1 1", ok, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            tests_failed++;
            $display("FAIL after_reset_6_4: got %h/%h/%b, want %h/%h/%b", got.quo, got.rem, got.dbz, e.quo, e.rem, e.dbz);
         end
      end
   endtask

   task automatic test_sweep();
      res_t e, got; int unsigned lat; logic iok, pok, ok;
      for (int s = 0; s < 2; s++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               run_op(4'(x), 4'(y), 1'(s), ref_div(4'(x), 4'(y), 1'(s)), $urandom_range(0, 2),
                      got, lat, iok, pok, ok);
               tests_run++;
               if (!ok || exp_q.size() != 1) begin
                  tests_failed++;
                  $display("FAIL sweep_order: a=%h b=%h s=%0d ok=%b queue=%0d, want 1 1", x, y, s, ok, exp_q.size());
                  exp_q.delete();
               end else begin
                  e = exp_q.pop_front();
                  if (got !== e || lat !== N || iok !== 1'b1 || pok !== 1'b1) begin
                     tests_failed++;
                     $display("FAIL sweep a=%h b=%h s=%0d: got %h/%h/%b lat %0d if %b%b, want %h/%h/%b lat %0d if 11",
                              x, y, s, got.quo, got.rem, got.dbz, lat, iok, pok, e.quo, e.rem, e.dbz, N);
                  end
               end
            end
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b1;
      arg_vld      = 1'b0;
      a            = '0;
      b            = '0;
      signed_div   = 1'b0;
      res_rdy      = 1'b0;
      #2;
      test_reset();
      test_unsigned_basic();
      test_signed();
      test_special();
      test_backpressure();
      test_reset_mid();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
